// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: 8N1 LSB-first UART transmitter fed by a small FIFO with valid/ready intake.
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4,
  parameter int ADDR_W       = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        Tx_Data,
  input  logic              Tx_Valid,
  output logic              Tx_Ready,
  output logic              Tx_Serial,
  output logic              Tx_Busy,
  output logic [ADDR_W:0]   Fifo_Count
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic [9:0]      LAST  = 10'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(FIFO_DEPTH);
  state_t              state_q, state_d;
  logic [9:0]          cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [7:0]          shift_q, shift_d;
  logic                serial_q, serial_d;
  logic [7:0]          mem_q [FIFO_DEPTH];
  logic [7:0]          mem_d [FIFO_DEPTH];
  logic [ADDR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                push, pop, bit_end, has_data;
  assign Tx_Ready   = count_q < DEPTH;
  assign Tx_Serial  = serial_q;
  assign Tx_Busy    = state_q != IDLE;
  assign Fifo_Count = count_q;
  assign push       = Tx_Valid && Tx_Ready;
  assign has_data   = count_q != '0;
  assign bit_end    = cnt_q == LAST;
  always_comb begin
    state_d  = state_q;
    cnt_d    = bit_end ? '0 : cnt_q + 10'd1;
    idx_d    = idx_q;
    serial_d = serial_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (has_data) begin
          pop      = 1'b1;
          state_d  = START;
          serial_d = 1'b0;
        end
      end
      START: if (bit_end) begin
        state_d  = DATA;
        idx_d    = '0;
        serial_d = shift_q[0];
      end
      DATA: if (bit_end) begin
        idx_d    = idx_q + 3'd1;
        state_d  = idx_q == 3'd7 ? STOP : DATA;
        serial_d = idx_q == 3'd7 ? 1'b1 : shift_q[idx_q + 3'd1];
      end
      STOP: if (bit_end) begin
        // Popping on the last stop cycle lets the next start bit follow with no idle gap.
        pop      = has_data;
        state_d  = has_data ? START : IDLE;
        serial_d = !has_data;
      end
    endcase
    shift_d = pop ? mem_q[rptr_q] : shift_q;
    mem_d   = mem_q;
    if (push) mem_d[wptr_q] = Tx_Data;
    wptr_d  = wptr_q + ADDR_W'(push);
    rptr_d  = rptr_q + ADDR_W'(pop);
    count_d = count_q + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(pop);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      serial_q <= 1'b1;
      mem_q    <= '{default: '0};
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      serial_q <= serial_d;
      mem_q    <= mem_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: directed bench for uart_tx_buffered with a sampling receiver model.
`timescale 1ns/1ps
module tb_uart_tx_buffered;
  localparam int C = 4;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] Tx_Data;
  logic       Tx_Valid;
  logic       Tx_Ready, Tx_Serial, Tx_Busy;
  logic [2:0] Fifo_Count;
  int errors = 0;
  int checks = 0;
  logic [7:0] rx_q[$];
  int  rx_t = 0;
  bit  rx_on = 0;
  logic [7:0] rx_sh = '0;
  int  busy_run = 0;
  bit  prev_busy = 0;

  uart_tx_buffered #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4), .ADDR_W(2)) dut (
    .clk(clk), .reset(reset), .Tx_Data(Tx_Data), .Tx_Valid(Tx_Valid),
    .Tx_Ready(Tx_Ready), .Tx_Serial(Tx_Serial), .Tx_Busy(Tx_Busy), .Fifo_Count(Fifo_Count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Receiver model: detects a start bit, samples each bit in its middle, records the byte.
  always @(negedge clk) begin
    if (reset) begin
      rx_on = 0;
      busy_run = 0;
      prev_busy = 0;
    end else begin
      if (Tx_Busy) busy_run = prev_busy ? busy_run + 1 : 1;
      prev_busy = Tx_Busy;
      if (!rx_on) begin
        if (Tx_Serial === 1'b0) begin
          rx_on = 1;
          rx_t = 0;
        end
      end else rx_t++;
      if (rx_on && (rx_t % C) == C / 2) begin
        if (rx_t / C == 0 && Tx_Serial !== 1'b0) rx_on = 0;
        else if (rx_t / C >= 1 && rx_t / C <= 8) rx_sh[rx_t / C - 1] = Tx_Serial;
        else if (rx_t / C == 9 && Tx_Serial === 1'b1) rx_q.push_back(rx_sh);
      end
      if (rx_on && rx_t == 10 * C - 1) rx_on = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rx(input string tag, input int n, input logic [39:0] bytes);
    logic [7:0] v;
    chk({tag, "_count"}, rx_q.size(), n);
    for (int i = 0; i < n; i++) begin
      v = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      chk({tag, "_byte"}, v, bytes[8*i +: 8]);
    end
  endtask

  task automatic frame(input string tag, input logic [7:0] b);
    logic e;
    for (int i = 0; i < 10 * C; i++) begin
      e = (i < C) ? 1'b0 : (i >= 9 * C) ? 1'b1 : b[i / C - 1];
      chk(tag, {Tx_Busy, Tx_Serial}, {1'b1, e});
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while (Tx_Busy !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n < max, 1);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    Tx_Valid = 1'b0;
    Tx_Data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_state", {Tx_Serial, Tx_Busy, Tx_Ready, Fifo_Count}, 6'b101000);
    reset = 1'b0;
    // 1: idle after reset
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("t1_idle", {Tx_Serial, Tx_Busy, Tx_Ready, Fifo_Count}, 6'b101000);
    end
    // 2: single byte, exact waveform and busy length
    rx_q.delete();
    Tx_Data = 8'hA5;
    Tx_Valid = 1'b1;
    @(negedge clk);
    Tx_Valid = 1'b0;
    chk("t2_count", Fifo_Count, 1);
    chk("t2_pre_serial", Tx_Serial, 1);
    @(negedge clk);
    frame("t2_frame", 8'hA5);
    chk("t2_busy_end", {Tx_Busy, Tx_Serial}, 2'b01);
    chk("t2_busy_run", busy_run, 40);
    chk_rx("t2_rx", 1, 40'hA5);
    // 3: three back-to-back frames
    repeat (3) @(negedge clk);
    rx_q.delete();
    Tx_Valid = 1'b1;
    Tx_Data = 8'h00;
    @(negedge clk);
    Tx_Data = 8'hFF;
    @(negedge clk);
    Tx_Data = 8'h3C;
    @(negedge clk);
    Tx_Valid = 1'b0;
    wait_idle("t3_timeout", 300);
    chk("t3_busy_run", busy_run, 120);
    chk_rx("t3_rx", 3, 40'h3CFF00);
    // 4: fill the FIFO while the first frame starts
    repeat (3) @(negedge clk);
    rx_q.delete();
    Tx_Valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      Tx_Data = 8'((i + 1) * 17);
      @(negedge clk);
    end
    Tx_Valid = 1'b0;
    chk("t4_full", {Tx_Ready, Fifo_Count}, 4'b0100);
    n = 0;
    while (Tx_Ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t4_ready_rise", n, 36);
    chk("t4_count_after_pop", Fifo_Count, 3);
    wait_idle("t4_timeout", 400);
    chk_rx("t4_rx", 5, 40'h5544332211);
    // 5: push coinciding with the STOP->START pop
    repeat (3) @(negedge clk);
    rx_q.delete();
    Tx_Valid = 1'b1;
    Tx_Data = 8'h5A;
    @(negedge clk);
    Tx_Data = 8'hC3;
    @(negedge clk);
    Tx_Data = 8'h81;
    @(negedge clk);
    Tx_Valid = 1'b0;
    repeat (38) @(negedge clk);
    chk("t5_pre_count", {Tx_Busy, Fifo_Count}, 4'b1010);
    Tx_Data = 8'h7E;
    Tx_Valid = 1'b1;
    @(negedge clk);
    Tx_Valid = 1'b0;
    chk("t5_post_count", {Tx_Busy, Tx_Ready, Fifo_Count}, 5'b11010);
    wait_idle("t5_timeout", 300);
    chk_rx("t5_rx", 4, 40'h7E81C35A);
    // 6: reset during data bit 3 with two bytes queued
    repeat (3) @(negedge clk);
    rx_q.delete();
    Tx_Valid = 1'b1;
    Tx_Data = 8'hE1;
    @(negedge clk);
    Tx_Data = 8'h42;
    @(negedge clk);
    Tx_Data = 8'h24;
    @(negedge clk);
    Tx_Valid = 1'b0;
    repeat (16) @(negedge clk);
    chk("t6_pre_reset", {Tx_Busy, Tx_Serial, Fifo_Count}, 5'b10010);
    reset = 1'b1;
    #1;
    chk("t6_in_reset", {Tx_Serial, Tx_Busy, Tx_Ready, Fifo_Count}, 6'b101000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      chk("t6_quiet", {Tx_Serial, Tx_Busy, Fifo_Count}, 5'b10000);
    end
    chk("t6_no_rx", rx_q.size(), 0);
    Tx_Data = 8'h96;
    Tx_Valid = 1'b1;
    @(negedge clk);
    Tx_Valid = 1'b0;
    @(negedge clk);
    chk("t6_restart", {Tx_Busy, Tx_Serial}, 2'b10);
    wait_idle("t6_timeout", 100);
    chk_rx("t6_rx", 1, 40'h96);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
